es_stream_decoder: RTL and testbench
====================================

// Module: es_stream_decoder
// PURPOSE
// - Receiving end of the deterministic stochastic bitstream link. It takes one serial stochastic
//   stream frame and converts it back to a binary count of ones, which is the stream's value.
// - Sits after the stochastic compute stages (AND-array multipliers, etc.) when a stream leaves
//   the clock domain or core. It replaces the free-running stoch2bin counter with a framed,
//   handshaked decoder.
// PARAMETERS
// - LEN_LOG2   4             frame length is 2**LEN_LOG2 stream bits
// - OUT_WIDTH  LEN_LOG2+1    result width; holds 0..2**LEN_LOG2 inclusive; must be >= LEN_LOG2+1
// PORTS
// - clk        in   1          single clock, rising edge
// - rst        in   1          asynchronous, active-high reset
// - start      in   1          one-cycle pulse that opens a new frame
// - bs_in      in   1          stochastic stream bit
// - bs_valid   in   1          bs_in is a frame bit this cycle
// - busy       out  1          frame in progress (state COUNT)
// - bin_out    out  OUT_WIDTH  decoded ones count; meaningful while out_valid=1
// - out_valid  out  1          result available
// - out_ready  in   1          consumer accepts result
// - frame_err  out  1          one-cycle pulse when a frame is aborted by start
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; busy=0, out_valid=0, frame_err=0, bin_out=0;
//   ones and bit-index counters cleared.
// - FSM states: IDLE, COUNT, HOLD.
//   - IDLE: start -> COUNT, clearing ones=0 and idx=0. bs_valid is ignored in IDLE.
//   - COUNT: on each bs_valid cycle, ones += bs_in and idx += 1. Cycles without bs_valid change
//     nothing, whatever bs_in is.
//   - COUNT: the bit accepted with idx == 2**LEN_LOG2-1 closes the frame. Next cycle: state=HOLD,
//     out_valid=1, bin_out = final ones, including that last bit.
//   - COUNT + start: abort. frame_err=1 next cycle; ones/idx cleared; stay in COUNT (new frame).
//     If bs_valid is high in the same cycle, that bit is discarded, not counted in either frame.
//   - HOLD: bin_out and out_valid stay stable until out_valid & out_ready.
//     - Handshake alone -> IDLE, out_valid=0 next cycle.
//     - Handshake + start in the same cycle -> COUNT directly (back-to-back frames), counters cleared.
//     - start without out_ready -> ignored, no frame_err.
// - Latency: out_valid rises exactly 1 cycle after the last frame bit is accepted.
//   Minimum frame time: 2**LEN_LOG2 cycles plus 1.
// - Width: ones counter is LEN_LOG2+1 bits, so an all-ones frame yields 2**LEN_LOG2 with no wrap.
//   bin_out is zero-extended to OUT_WIDTH.
// - bin_out holds its last value after the handshake; it is cleared only by rst.
// CONFIGURATION
// - Macro ES_DEC_EARLY_TERM_EN.
// - Defined: the stream is unary/thermometer coded (ones first), as produced by sng_dsc.
//   In COUNT, the first accepted bs_in=0 closes the frame immediately. That 0 is not counted.
//   Next cycle: HOLD, bin_out = ones so far. A frame with no 0 closes at the full length as usual.
// - Undefined: every frame runs the full 2**LEN_LOG2 bits and a 0 has no special meaning.
//   Non-unary streams are then decoded correctly.
// STRUCTURE
// - Package es_dec_pkg:
//   - state enum {IDLE, COUNT, HOLD};
//   - localparam function frame_len(LEN_LOG2) = 2**LEN_LOG2;
//   - index-width and count-width constants.
// - Sub-module es_bit_acc, a ones/index accumulator:
//   - inputs: synchronous clear, enable, bit;
//   - outputs: ones count and a last-bit flag.
// - The top level holds the FSM, the output register and the handshake.
// TESTING (LEN_LOG2=4, frame=16 bits)
// - Reset: rst pulse mid-COUNT -> next edge busy=0, out_valid=0, bin_out=0, IDLE; no frame_err.
// - Basic: start, then 16 valid bits with 5 ones scattered.
//   -> out_valid=1 one cycle after the 16th bit, bin_out=5.
// - Bounds: 16 ones -> bin_out=16 (no wrap); 16 zeros -> bin_out=0 (macro undefined).
// - Gaps: 16 valid bits interleaved with bs_valid=0 cycles carrying bs_in=1, 7 valid ones
//   -> bin_out=7.
// - Backpressure:
//   - out_ready=0 for 3 cycles -> bin_out/out_valid stable; start during HOLD ignored.
//   - start together with out_ready -> busy=1 next cycle and a correct second result.
// - Abort: start after 7 bits -> frame_err 1 cycle; then a 16-bit frame with 9 ones -> bin_out=9.
// - ES_DEC_EARLY_TERM_EN defined: stream 1,1,1,1,1,0,...
//   -> out_valid one cycle after the 0 (6th bit), bin_out=5.

Source files
------------

// File: rtl/es_dec_pkg.sv
// Shared types and width helpers for the framed stochastic stream decoder.
package es_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned DEF_LEN_LOG2 = 4;

  function automatic int unsigned frame_len(input int unsigned len_log2);
    return 32'd1 << len_log2;
  endfunction

  function automatic int unsigned idx_width(input int unsigned len_log2);
    return len_log2;
  endfunction

  // One extra bit so an all-ones frame reports 2**len_log2 without wrapping.
  function automatic int unsigned cnt_width(input int unsigned len_log2);
    return len_log2 + 1;
  endfunction

  localparam int unsigned DEF_IDX_W = idx_width(DEF_LEN_LOG2);
  localparam int unsigned DEF_CNT_W = cnt_width(DEF_LEN_LOG2);

endpackage

// File: rtl/es_stream_decoder_acc.sv
// es_bit_acc: ones/bit-index accumulator for one stream frame; clear has priority over enable.
module es_bit_acc
  import es_dec_pkg::*;
#(
  parameter int unsigned LEN_LOG2 = DEF_LEN_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              bit_in,
  output logic [LEN_LOG2:0] ones,
  output logic              last
);

  localparam int unsigned IDX_W    = idx_width(LEN_LOG2);
  localparam int unsigned CNT_W    = cnt_width(LEN_LOG2);
  localparam int unsigned LAST_IDX = frame_len(LEN_LOG2) - 1;

  logic [CNT_W-1:0] ones_q, ones_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    ones_d = ones_q;
    idx_d  = idx_q;
    if (clr) begin
      ones_d = '0;
      idx_d  = '0;
    end else if (en) begin
      ones_d = ones_q + CNT_W'(bit_in);
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
      idx_q  <= '0;
    end else begin
      ones_q <= ones_d;
      idx_q  <= idx_d;
    end
  end

  assign ones = ones_q;
  assign last = (idx_q == IDX_W'(LAST_IDX));

endmodule

// File: rtl/es_stream_decoder.sv
// Framed, handshaked stochastic stream decoder (IDLE/COUNT/HOLD).
// ES_DEC_EARLY_TERM_EN: treat the stream as unary, closing the frame on the first 0.
module es_stream_decoder
  import es_dec_pkg::*;
#(
  parameter int unsigned LEN_LOG2  = DEF_LEN_LOG2,
  parameter int unsigned OUT_WIDTH = LEN_LOG2 + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bs_in,
  input  logic                 bs_valid,
  output logic                 busy,
  output logic [OUT_WIDTH-1:0] bin_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err
);

  localparam int unsigned CNT_W = cnt_width(LEN_LOG2);

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [OUT_WIDTH-1:0] bin_out_q, bin_out_d;

  logic             acc_clr, acc_en, acc_last, close;
  logic [CNT_W-1:0] acc_ones, final_ones;

  es_bit_acc #(.LEN_LOG2(LEN_LOG2)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .en     (acc_en),
    .bit_in (bs_in),
    .ones   (acc_ones),
    .last   (acc_last)
  );

  // A closing 0 adds nothing, so one sum serves both full-length and early closes.
  assign final_ones = acc_ones + CNT_W'(bs_in);

`ifdef ES_DEC_EARLY_TERM_EN
  assign close = acc_last | ~bs_in;
`else
  assign close = acc_last;
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    bin_out_d   = bin_out_q;
    frame_err_d = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COUNT;
          busy_d  = 1'b1;
          acc_clr = 1'b1;
        end
      end
      COUNT: begin
        if (start) begin
          // Abort: any bit presented alongside start belongs to neither frame.
          frame_err_d = 1'b1;
          acc_clr     = 1'b1;
        end else if (bs_valid) begin
          acc_en = 1'b1;
          if (close) begin
            state_d     = HOLD;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
            bin_out_d   = OUT_WIDTH'(final_ones);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (start) begin
            state_d = COUNT;
            busy_d  = 1'b1;
            acc_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      bin_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      bin_out_q   <= bin_out_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign bin_out   = bin_out_q;

endmodule

// File: tb/tb_es_stream_decoder.sv
// Scoreboard bench for es_stream_decoder (LEN_LOG2=4); handles ES_DEC_EARLY_TERM_EN too.
module tb_es_stream_decoder;

  localparam int unsigned LEN_LOG2  = 4;
  localparam int unsigned OUT_WIDTH = LEN_LOG2 + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 bs_in;
  logic                 bs_valid;
  logic                 busy;
  logic [OUT_WIDTH-1:0] bin_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 frame_err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned exp_q[$];

  es_stream_decoder #(.LEN_LOG2(LEN_LOG2), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bs_in     (bs_in),
    .bs_valid  (bs_valid),
    .busy      (busy),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Index of the bit that closes the frame.
  function automatic int unsigned close_idx(input logic [15:0] bits);
`ifdef ES_DEC_EARLY_TERM_EN
    for (int i = 0; i < 16; i++)
      if (!bits[i]) return i;
`endif
    return 15;
  endfunction

  function automatic int unsigned model_count(input logic [15:0] bits);
    int unsigned n = 0;
    for (int i = 0; i <= int'(close_idx(bits)); i++)
      n += bits[i];
    return n;
  endfunction

  // Result is checked when the handshake is seen.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else                   chk("bin_out", 32'(bin_out), exp_q.pop_front());
    end
  end

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic send_bits(input logic [15:0] bits, input bit gaps);
    int unsigned n;
    n = close_idx(bits);
    exp_q.push_back(model_count(bits));
    for (int i = 0; i <= int'(n); i++) begin
      bs_valid = 1'b1;
      bs_in    = bits[i];
      if (i == int'(n)) chk("valid_before_last", 32'(out_valid), 0);
      step();
      bs_valid = 1'b0;
      bs_in    = 1'b0;
      if (gaps && i < int'(n)) begin
        bs_in = 1'b1;
        step();
        bs_in = 1'b0;
      end
    end
    chk("latency_valid", 32'(out_valid), 1);
    chk("busy_in_hold", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned exp_hold;
    rst = 1'b1; start = 1'b0; bs_in = 1'b0; bs_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_bin", 32'(bin_out), 0);
    chk("rst_err", 32'(frame_err), 0);
    rst = 1'b0;
    step();

    // scattered, all ones, all zeros
    start_frame(); send_bits(16'h4891, 1'b0); step();
    chk("idle_after_hs", 32'(out_valid), 0);
    start_frame(); send_bits(16'hFFFF, 1'b0); step();
    start_frame(); send_bits(16'h0000, 1'b0); step();
    // bs_valid=0 gaps carrying bs_in=1
    start_frame(); send_bits(16'h5B03, 1'b1); step();

    // backpressure, then start together with handshake
    out_ready = 1'b0;
    start_frame(); send_bits(16'h0F0F, 1'b0);
    exp_hold = model_count(16'h0F0F);
    for (int k = 0; k < 3; k++) begin
      start = (k == 1);
      step();
      start = 1'b0;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_bin", 32'(bin_out), exp_hold);
      chk("hold_err", 32'(frame_err), 0);
      chk("hold_busy", 32'(busy), 0);
    end
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_valid", 32'(out_valid), 0);
    send_bits(16'hAAAA, 1'b0); step();

    // abort after 7 bits; the bit alongside start is discarded
    start_frame();
    for (int i = 0; i < 7; i++) begin
      bs_valid = 1'b1; bs_in = 1'b1;
      step();
    end
    start = 1'b1; bs_valid = 1'b1; bs_in = 1'b1;
    step();
    start = 1'b0; bs_valid = 1'b0; bs_in = 1'b0;
    chk("abort_err", 32'(frame_err), 1);
    chk("abort_busy", 32'(busy), 1);
    chk("abort_valid", 32'(out_valid), 0);
    send_bits(16'h01FF, 1'b0);
    step();
    chk("abort_err_pulse", 32'(frame_err), 0);

    // unary stream 1,1,1,1,1,0,...
    start_frame(); send_bits(16'hFFDF, 1'b0); step();

    // async reset mid-frame
    start_frame();
    for (int i = 0; i < 5; i++) begin
      bs_valid = 1'b1; bs_in = 1'b1;
      step();
    end
    bs_valid = 1'b0; bs_in = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_bin", 32'(bin_out), 0);
    chk("midrst_err", 32'(frame_err), 0);
    rst = 1'b0;
    step();
    chk("post_rst_idle", 32'(busy), 0);
    start_frame(); send_bits(16'h1248, 1'b1); step();

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
